conbus_arbiter: RTL and testbench

CONBUS_ARBITER -- requirements
Module: conbus_arbiter

---
 rtl/conbus_arb_pkg.sv | 17 +
 rtl/conbus_rr_pick.sv | 41 ++++
 rtl/conbus_arbiter.sv | 137 +++++++++++++
 tb/tb_conbus_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/conbus_arb_pkg.sv
// rtl/conbus_arb_pkg.sv - shared constants and state encoding for the conbus arbiter
// Purpose: state enum, default master count and index width used by the arbiter
//          and its round-robin picker.
// Ports:   none (package).
package conbus_arb_pkg;

  localparam int NMASTERS_DEF = 6;
  localparam int IDX_W        = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ERR   = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

endpackage

// File: rtl/conbus_rr_pick.sv
// rtl/conbus_rr_pick.sv - combinational round-robin requester picker
// Purpose: pick the first set request bit searching from last_idx+1 upward,
//          wrapping through 0 and ending at last_idx itself.
// Ports:   req        - per-master request vector
//          last_idx   - index of the most recently granted master
//          pick_oh    - one-hot of the winner (zero if none)
//          pick_idx   - binary index of the winner
//          pick_valid - at least one request was found
module conbus_rr_pick
  import conbus_arb_pkg::*;
#(
  parameter int NMASTERS = NMASTERS_DEF
) (
  input  logic [NMASTERS-1:0] req,
  input  logic [IDX_W-1:0]    last_idx,
  output logic [NMASTERS-1:0] pick_oh,
  output logic [IDX_W-1:0]    pick_idx,
  output logic                pick_valid
);

  // Walk offsets from farthest to nearest so the nearest requester after
  // last_idx is the final (winning) assignment; offset NMASTERS is last_idx
  // itself, which therefore ranks lowest.
  always_comb begin
    pick_oh    = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    for (int k = NMASTERS; k >= 1; k--) begin
      int c;
      c = int'(last_idx) + k;
      if (c >= NMASTERS) c = c - NMASTERS;
      if (c < NMASTERS && req[c[IDX_W-1:0]]) begin
        pick_oh                = '0;
        pick_oh[c[IDX_W-1:0]]  = 1'b1;
        pick_idx               = c[IDX_W-1:0];
        pick_valid             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/conbus_arbiter.sv
// rtl/conbus_arbiter.sv - round-robin Wishbone bus arbiter with stall timeout
// Purpose: grants conbus to one master at a time (no preemption), regrants
//          without a bubble, and flags masters whose slave stalls too long.
// Ports:   sys_clk, sys_rst_n      - clock, async active-low reset
//          m_cyc_i                 - per-master CYC requests
//          bus_stb_i, bus_ack_i    - post-mux STB / ACK of the granted transfer
//          gnt_o, gnt_idx_o        - one-hot and binary grant
//          gnt_valid_o             - a grant is active
//          to_err_o                - one-cycle ERR pulse on timeout
//          to_master_o, to_count_o - last timed-out master, saturating count
module conbus_arbiter
  import conbus_arb_pkg::*;
#(
  parameter int NMASTERS = NMASTERS_DEF,
  parameter int TO_W     = 10
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [NMASTERS-1:0] m_cyc_i,
  input  logic                bus_stb_i,
  input  logic                bus_ack_i,
  output logic [NMASTERS-1:0] gnt_o,
  output logic [IDX_W-1:0]    gnt_idx_o,
  output logic                gnt_valid_o,
  output logic                to_err_o,
  output logic [IDX_W-1:0]    to_master_o,
  output logic [7:0]          to_count_o
);

  localparam logic [TO_W-1:0] TIMER_MAX = '1;

  arb_state_e          state_q, state_d;
  logic [TO_W-1:0]     timer_q, timer_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [NMASTERS-1:0] gnt_d;
  logic [IDX_W-1:0]    idx_d;
  logic                valid_d;
  logic                err_d;
  logic [IDX_W-1:0]    master_d;
  logic [7:0]          count_d;
  logic                owner_cyc;
  logic                stall;
  logic                regrant;

  logic [NMASTERS-1:0] pick_oh;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;

  conbus_rr_pick #(.NMASTERS(NMASTERS)) u_pick (
    .req        (m_cyc_i),
    .last_idx   (last_q),
    .pick_oh    (pick_oh),
    .pick_idx   (pick_idx),
    .pick_valid (pick_valid)
  );

  // Masking with the one-hot grant avoids indexing by a possibly wider idx.
  assign owner_cyc = |(m_cyc_i & gnt_o);
  assign stall     = bus_stb_i & ~bus_ack_i;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    last_d   = last_q;
    gnt_d    = gnt_o;
    idx_d    = gnt_idx_o;
    err_d    = 1'b0;
    master_d = to_master_o;
    count_d  = to_count_o;
    regrant  = 1'b0;

    case (state_q)
      IDLE: regrant = 1'b1;
      GRANT: begin
        if (!owner_cyc) begin
          regrant = 1'b1;
        end else if (stall) begin
          if (timer_q == TIMER_MAX) begin
            state_d  = ERR;
            err_d    = 1'b1;
            master_d = gnt_idx_o;
            if (to_count_o != 8'hff) count_d = to_count_o + 8'd1;
          end else begin
            timer_d = timer_q + TO_W'(1);
          end
        end else begin
          timer_d = '0;
        end
      end
      ERR:   state_d = DRAIN;
      // Timer frozen and ack ignored until the owner releases CYC.
      DRAIN: if (!owner_cyc) regrant = 1'b1;
      default: state_d = IDLE;
    endcase

    if (regrant) begin
      timer_d = '0;
      if (pick_valid) begin
        state_d = GRANT;
        gnt_d   = pick_oh;
        idx_d   = pick_idx;
        last_d  = pick_idx;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
      end
    end

    valid_d = |gnt_d;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      last_q      <= IDX_W'(NMASTERS - 1);
      gnt_o       <= '0;
      gnt_idx_o   <= '0;
      gnt_valid_o <= 1'b0;
      to_err_o    <= 1'b0;
      to_master_o <= '0;
      to_count_o  <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      last_q      <= last_d;
      gnt_o       <= gnt_d;
      gnt_idx_o   <= idx_d;
      gnt_valid_o <= valid_d;
      to_err_o    <= err_d;
      to_master_o <= master_d;
      to_count_o  <= count_d;
    end
  end

endmodule

// File: tb/tb_conbus_arbiter.sv
// tb/tb_conbus_arbiter.sv - directed self-checking bench for conbus_arbiter
module tb_conbus_arbiter;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [5:0] m_cyc_i = '0;
  logic       bus_stb_i = 1'b0;
  logic       bus_ack_i = 1'b0;
  logic [5:0] gnt_o;
  logic [2:0] gnt_idx_o;
  logic       gnt_valid_o;
  logic       to_err_o;
  logic [2:0] to_master_o;
  logic [7:0] to_count_o;

  // Short-timeout instance so 256 timeouts stay cheap.
  logic [5:0] s_cyc = '0;
  logic       s_stb = 1'b0;
  logic       s_ack = 1'b0;
  logic [5:0] s_gnt;
  logic [2:0] s_idx;
  logic       s_valid;
  logic       s_err;
  logic [2:0] s_master;
  logic [7:0] s_count;

  int n_vec = 0;
  int n_err = 0;

  conbus_arbiter #(.NMASTERS(6), .TO_W(10)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .m_cyc_i(m_cyc_i),
    .bus_stb_i(bus_stb_i), .bus_ack_i(bus_ack_i), .gnt_o(gnt_o),
    .gnt_idx_o(gnt_idx_o), .gnt_valid_o(gnt_valid_o), .to_err_o(to_err_o),
    .to_master_o(to_master_o), .to_count_o(to_count_o)
  );

  conbus_arbiter #(.NMASTERS(6), .TO_W(2)) dut_sat (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .m_cyc_i(s_cyc),
    .bus_stb_i(s_stb), .bus_ack_i(s_ack), .gnt_o(s_gnt),
    .gnt_idx_o(s_idx), .gnt_valid_o(s_valid), .to_err_o(s_err),
    .to_master_o(s_master), .to_count_o(s_count)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic apply_reset();
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++; if (gnt_o !== 6'b0) begin n_err++; $display("FAIL reset_gnt: got %b want 000000", gnt_o); end
    n_vec++; if (gnt_idx_o !== 3'd0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", gnt_idx_o); end
    n_vec++; if (gnt_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", gnt_valid_o); end
    n_vec++; if (to_err_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", to_err_o); end
    n_vec++; if (to_master_o !== 3'd0) begin n_err++; $display("FAIL reset_master: got %0d want 0", to_master_o); end
    n_vec++; if (to_count_o !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", to_count_o); end
  endtask

  task automatic test_handover();
    m_cyc_i = 6'b000011;
    step();
    n_vec++; if (gnt_o !== 6'b000001) begin n_err++; $display("FAIL ho_first_gnt: got %b want 000001", gnt_o); end
    n_vec++; if (gnt_valid_o !== 1'b1) begin n_err++; $display("FAIL ho_first_valid: got %b want 1", gnt_valid_o); end
    m_cyc_i = 6'b000010;
    step();
    n_vec++; if (gnt_o !== 6'b000010) begin n_err++; $display("FAIL ho_second_gnt: got %b want 000010", gnt_o); end
    n_vec++; if (gnt_idx_o !== 3'd1) begin n_err++; $display("FAIL ho_second_idx: got %0d want 1", gnt_idx_o); end
    m_cyc_i = 6'b000000;
    step();
    n_vec++; if (gnt_o !== 6'b0) begin n_err++; $display("FAIL ho_idle_gnt: got %b want 000000", gnt_o); end
    n_vec++; if (gnt_valid_o !== 1'b0) begin n_err++; $display("FAIL ho_idle_valid: got %b want 0", gnt_valid_o); end
  endtask

  task automatic test_round_robin();
    logic [5:0] cur, nxt;
    m_cyc_i = 6'b0;
    apply_reset();
    m_cyc_i = 6'b111111;
    step();
    n_vec++; if (gnt_o !== 6'b000001) begin n_err++; $display("FAIL rr_start: got %b want 000001", gnt_o); end
    for (int g = 0; g < 6; g++) begin
      cur = 6'(1) << g;
      nxt = 6'(1) << ((g + 1) % 6);
      bus_stb_i = 1'b1; bus_ack_i = 1'b1;
      step();
      n_vec++; if (gnt_o !== cur) begin n_err++; $display("FAIL rr_hold_%0d: got %b want %b", g, gnt_o, cur); end
      m_cyc_i = 6'b111111 & ~cur;
      bus_stb_i = 1'b0; bus_ack_i = 1'b0;
      step();
      m_cyc_i = 6'b111111;
      n_vec++; if (gnt_o !== nxt) begin n_err++; $display("FAIL rr_next_%0d: got %b want %b", g, gnt_o, nxt); end
      n_vec++; if (gnt_idx_o !== 3'((g + 1) % 6)) begin n_err++; $display("FAIL rr_idx_%0d: got %0d want %0d", g, gnt_idx_o, (g + 1) % 6); end
      n_vec++; if (!$onehot(gnt_o)) begin n_err++; $display("FAIL rr_onehot_%0d: got %b want one bit", g, gnt_o); end
    end
    m_cyc_i = 6'b0;
    step();
  endtask

  task automatic test_timeout();
    int n;
    m_cyc_i = 6'b000100; bus_stb_i = 1'b1; bus_ack_i = 1'b0;
    step();
    n_vec++; if (gnt_o !== 6'b000100) begin n_err++; $display("FAIL to_gnt: got %b want 000100", gnt_o); end
    n = 0;
    while (!to_err_o && n < 1100) begin step(); n++; end
    n_vec++; if (n !== 1024) begin n_err++; $display("FAIL to_latency: got %0d cycles want 1024", n); end
    n_vec++; if (to_master_o !== 3'd2) begin n_err++; $display("FAIL to_master: got %0d want 2", to_master_o); end
    n_vec++; if (to_count_o !== 8'd1) begin n_err++; $display("FAIL to_count: got %0d want 1", to_count_o); end
    n_vec++; if (gnt_o !== 6'b000100) begin n_err++; $display("FAIL to_gnt_err: got %b want 000100", gnt_o); end
    bus_ack_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_vec++; if (to_err_o !== 1'b0) begin n_err++; $display("FAIL to_pulse_%0d: got %b want 0", k, to_err_o); end
      n_vec++; if (gnt_o !== 6'b000100) begin n_err++; $display("FAIL to_drain_gnt_%0d: got %b want 000100", k, gnt_o); end
    end
    m_cyc_i = 6'b0; bus_stb_i = 1'b0; bus_ack_i = 1'b0;
    step();
    n_vec++; if (gnt_o !== 6'b0) begin n_err++; $display("FAIL to_release: got %b want 000000", gnt_o); end
  endtask

  task automatic test_ack_at_threshold();
    int errs;
    m_cyc_i = 6'b000100; bus_stb_i = 1'b1; bus_ack_i = 1'b0;
    step();
    errs = 0;
    for (int k = 0; k < 1023; k++) begin
      step();
      if (to_err_o) errs++;
    end
    bus_ack_i = 1'b1;
    step();
    if (to_err_o) errs++;
    bus_ack_i = 1'b0;
    step();
    if (to_err_o) errs++;
    n_vec++; if (errs !== 0) begin n_err++; $display("FAIL ack_thr_err: got %0d pulses want 0", errs); end
    n_vec++; if (to_count_o !== 8'd1) begin n_err++; $display("FAIL ack_thr_count: got %0d want 1", to_count_o); end
    n_vec++; if (gnt_o !== 6'b000100) begin n_err++; $display("FAIL ack_thr_gnt: got %b want 000100", gnt_o); end
    m_cyc_i = 6'b0; bus_stb_i = 1'b0;
    step();
  endtask

  task automatic test_saturate();
    int n;
    int expc;
    s_cyc = 6'b000001; s_stb = 1'b1; s_ack = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      n = 0;
      while (!s_err && n < 12) begin step(); n++; end
      if (!s_err) begin
        n_vec++; n_err++;
        $display("FAIL sat_wait_%0d: got no timeout want pulse", i);
        break;
      end
      expc = (i > 255) ? 255 : i;
      n_vec++; if (s_count !== 8'(expc)) begin n_err++; $display("FAIL sat_count_%0d: got %0d want %0d", i, s_count, expc); end
      s_cyc = 6'b0;
      step();
      step();
      s_cyc = 6'b000001;
    end
    s_cyc = 6'b0; s_stb = 1'b0;
    step();
  endtask

  task automatic test_reset_in_drain();
    int n;
    m_cyc_i = 6'b000100; bus_stb_i = 1'b1; bus_ack_i = 1'b0;
    step();
    n = 0;
    while (!to_err_o && n < 1100) begin step(); n++; end
    step();
    n_vec++; if (gnt_o !== 6'b000100 || to_err_o !== 1'b0) begin n_err++; $display("FAIL rd_drain: got gnt %b err %b want 000100 0", gnt_o, to_err_o); end
    n_vec++; if (to_count_o !== 8'd2) begin n_err++; $display("FAIL rd_count: got %0d want 2", to_count_o); end
    m_cyc_i = 6'b111111; bus_stb_i = 1'b0;
    #2 sys_rst_n = 1'b0;
    #1;
    n_vec++; if (gnt_o !== 6'b0 || gnt_valid_o !== 1'b0 || gnt_idx_o !== 3'd0) begin n_err++; $display("FAIL rd_async_gnt: got %b/%b/%0d want 0", gnt_o, gnt_valid_o, gnt_idx_o); end
    n_vec++; if (to_err_o !== 1'b0 || to_master_o !== 3'd0 || to_count_o !== 8'd0) begin n_err++; $display("FAIL rd_async_to: got %b/%0d/%0d want 0", to_err_o, to_master_o, to_count_o); end
    #2 sys_rst_n = 1'b1;
    step();
    n_vec++; if (gnt_o !== 6'b000001) begin n_err++; $display("FAIL rd_first: got %b want 000001", gnt_o); end
  endtask

  initial begin
    test_reset();
    test_handover();
    test_round_robin();
    test_timeout();
    test_ack_at_threshold();
    test_saturate();
    test_reset_in_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
